// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the register file write port from the memory-load
// and ALU paths, with forwarding of queued values onto both read ports.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memValid,
    input  logic [3:0]    memDest,
    input  logic [31:0]   memData,
    output logic          memReady,
    input  logic          aluValid,
    input  logic [3:0]    aluDest,
    input  logic [31:0]   aluData,
    output logic          aluReady,
    output logic          writeEnable,
    output logic [3:0]    writeDestination,
    output logic [31:0]   writeData,
    input  logic [3:0]    readReg1,
    input  logic [3:0]    readReg2,
    input  logic [31:0]   rfData1,
    input  logic [31:0]   rfData2,
    output logic [31:0]   readData1,
    output logic [31:0]   readData2,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, alu_ptr;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    dest_q [DEPTH];
    logic [3:0]    dest_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic          mem_acc, alu_acc, deq;

    // Readiness looks only at the registered count; a dequeue this cycle gives no credit.
    always_comb begin
        memReady = {1'b0, count_q} < DEPTH_X;
        mem_acc  = memValid & memReady;
        aluReady = ({1'b0, count_q} + {{CW{1'b0}}, mem_acc}) < DEPTH_X;
        alu_acc  = aluValid & aluReady;
        deq      = (count_q != '0);
    end

    always_comb begin
        dest_d  = dest_q;
        data_d  = data_q;
        alu_ptr = mem_acc ? (wptr_q + PW'(1)) : wptr_q;
        if (mem_acc) begin
            dest_d[wptr_q] = memDest;
            data_d[wptr_q] = memData;
        end
        if (alu_acc) begin
            dest_d[alu_ptr] = aluDest;
            data_d[alu_ptr] = aluData;
        end
        wptr_d  = wptr_q + PW'(mem_acc) + PW'(alu_acc);
        rptr_d  = rptr_q + PW'(deq);
        count_d = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage is only observable through occupied slots, so it needs no reset.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end

    always_comb begin
        writeEnable      = deq;
        writeDestination = deq ? dest_q[rptr_q] : '0;
        writeData        = deq ? data_q[rptr_q] : '0;
        count            = count_q;
        empty            = !deq;
        full             = ({1'b0, count_q} == DEPTH_X);
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        readData1 = rfData1;
        readData2 = rfData2;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = rptr_q + PW'(i);
            if (i < 32'(count_q)) begin
                if (dest_q[idx] == readReg1) readData1 = data_q[idx];
                if (dest_q[idx] == readReg2) readData2 = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: vector table plus reset, wrap, backpressure sequences.
module tb_reg_writeback_queue;

    logic        clk;
    logic        reset;
    logic        memValid, aluValid;
    logic [3:0]  memDest, aluDest, readReg1, readReg2;
    logic [31:0] memData, aluData, rfData1, rfData2;
    logic        memReady, aluReady, writeEnable, full, empty;
    logic [3:0]  writeDestination;
    logic [31:0] writeData, readData1, readData2;
    logic [2:0]  count;

    logic        m2v, a2v;
    logic [3:0]  m2d, a2d;
    logic [31:0] m2dat, a2dat;
    logic        m2rdy, a2rdy, we2, full2, empty2;
    logic [3:0]  wd2;
    logic [31:0] wdat2, rd2a, rd2b;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    reg_writeback_queue #(.DEPTH(4), .CW(3)) u_dut (
        .clk(clk), .reset(reset),
        .memValid(memValid), .memDest(memDest), .memData(memData), .memReady(memReady),
        .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady),
        .writeEnable(writeEnable), .writeDestination(writeDestination), .writeData(writeData),
        .readReg1(readReg1), .readReg2(readReg2), .rfData1(rfData1), .rfData2(rfData2),
        .readData1(readData1), .readData2(readData2),
        .count(count), .full(full), .empty(empty)
    );

    reg_writeback_queue #(.DEPTH(2), .CW(2)) u_d2 (
        .clk(clk), .reset(reset),
        .memValid(m2v), .memDest(m2d), .memData(m2dat), .memReady(m2rdy),
        .aluValid(a2v), .aluDest(a2d), .aluData(a2dat), .aluReady(a2rdy),
        .writeEnable(we2), .writeDestination(wd2), .writeData(wdat2),
        .readReg1(4'h0), .readReg2(4'h1), .rfData1(32'h0), .rfData2(32'h0),
        .readData1(rd2a), .readData2(rd2b),
        .count(cnt2), .full(full2), .empty(empty2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic mv; logic [3:0] md; logic [31:0] mdat;
        logic av; logic [3:0] ad; logic [31:0] adat;
        logic [3:0] rr1; logic [3:0] rr2; logic [31:0] rf1; logic [31:0] rf2;
        logic [2:0] cnt; logic we; logic [3:0] wdest; logic [31:0] wdata;
        logic mrdy; logic ardy; logic [31:0] rd1; logic [31:0] rd2;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [3:0] md, input logic [31:0] mdat,
                         input logic av, input logic [3:0] ad, input logic [31:0] adat);
        memValid = mv; memDest = md; memData = mdat;
        aluValid = av; aluDest = ad; aluData = adat;
    endtask

    task automatic drive2(input logic mv, input logic [3:0] md, input logic av, input logic [3:0] ad);
        m2v = mv; m2d = md; m2dat = {24'hA0A0A0, 4'h0, md};
        a2v = av; a2d = ad; a2dat = {24'hA0A0A0, 4'h0, ad};
    endtask

    task automatic chk2(input string tag, input logic [1:0] c, input logic f, input logic mr,
                        input logic ar, input logic w, input logic [3:0] d);
        chk({tag, " cnt"}, 32'(cnt2), 32'(c));
        chk({tag, " full"}, 32'(full2), 32'(f));
        chk({tag, " memReady"}, 32'(m2rdy), 32'(mr));
        chk({tag, " aluReady"}, 32'(a2rdy), 32'(ar));
        chk({tag, " we"}, 32'(we2), 32'(w));
        chk({tag, " wdest"}, 32'(wd2), 32'(d));
        if (w) chk({tag, " wdata"}, wdat2, {24'hA0A0A0, 4'h0, d});
    endtask

    initial begin
        //          mv md   mdat          av ad   adat          rr1  rr2  rf1           rf2            cnt  we wdest wdata         mr ar rd1           rd2
        vecs[0]  = '{1'b0,4'h0,32'h0,        1'b1,4'h8,32'hAAAAAAAA,4'h8,4'h0,32'h5,       32'h7,        3'd0,1'b0,4'h0,32'h0,        1'b1,1'b1,32'h5,       32'h7};
        vecs[1]  = '{1'b0,4'h0,32'h0,        1'b0,4'h0,32'h0,       4'h8,4'h0,32'h5,       32'h7,        3'd1,1'b1,4'h8,32'hAAAAAAAA, 1'b1,1'b1,32'hAAAAAAAA,32'h7};
        vecs[2]  = '{1'b1,4'h3,32'h11111111, 1'b1,4'h3,32'h22222222,4'h3,4'h8,32'h0,       32'h9,        3'd0,1'b0,4'h0,32'h0,        1'b1,1'b1,32'h0,       32'h9};
        vecs[3]  = '{1'b0,4'h0,32'h0,        1'b0,4'h0,32'h0,       4'h3,4'h3,32'h0,       32'h0,        3'd2,1'b1,4'h3,32'h11111111, 1'b1,1'b1,32'h22222222,32'h22222222};
        vecs[4]  = '{1'b0,4'h0,32'h0,        1'b0,4'h0,32'h0,       4'h3,4'h8,32'h0,       32'h99,       3'd1,1'b1,4'h3,32'h22222222, 1'b1,1'b1,32'h22222222,32'h99};
        vecs[5]  = '{1'b1,4'h1,32'h1001,     1'b1,4'h2,32'h2002,    4'h3,4'h1,32'h33,      32'h10,       3'd0,1'b0,4'h0,32'h0,        1'b1,1'b1,32'h33,      32'h10};
        vecs[6]  = '{1'b1,4'h4,32'h4004,     1'b1,4'h5,32'h5005,    4'h2,4'h5,32'h0,       32'h50,       3'd2,1'b1,4'h1,32'h1001,     1'b1,1'b1,32'h2002,    32'h50};
        vecs[7]  = '{1'b1,4'h6,32'h6006,     1'b1,4'h7,32'h7007,    4'h1,4'h5,32'h1111,    32'h0,        3'd3,1'b1,4'h2,32'h2002,     1'b1,1'b0,32'h1111,    32'h5005};
        vecs[8]  = '{1'b0,4'h6,32'h6006,     1'b1,4'h7,32'h7007,    4'h5,4'h7,32'h0,       32'hEE,       3'd3,1'b1,4'h4,32'h4004,     1'b1,1'b1,32'h5005,    32'hEE};
        vecs[9]  = '{1'b0,4'h0,32'h0,        1'b0,4'h0,32'h0,       4'h7,4'h4,32'h0,       32'h44,       3'd3,1'b1,4'h5,32'h5005,     1'b1,1'b1,32'h7007,    32'h44};
        vecs[10] = '{1'b0,4'h0,32'h0,        1'b0,4'h0,32'h0,       4'h6,4'h7,32'h0,       32'h0,        3'd2,1'b1,4'h6,32'h6006,     1'b1,1'b1,32'h6006,    32'h7007};
        vecs[11] = '{1'b0,4'h0,32'h0,        1'b0,4'h0,32'h0,       4'h6,4'h7,32'h66,      32'h0,        3'd1,1'b1,4'h7,32'h7007,     1'b1,1'b1,32'h66,      32'h7007};
        vecs[12] = '{1'b0,4'h0,32'h0,        1'b0,4'h0,32'h0,       4'h7,4'hF,32'h77,      32'hF,        3'd0,1'b0,4'h0,32'h0,        1'b1,1'b1,32'h77,      32'hF};

        // Reset held with a request pending: nothing may be queued.
        reset = 1'b0;
        drive(1'b1, 4'h5, 32'h123, 1'b0, 4'h0, 32'h0);
        drive2(1'b0, 4'h0, 1'b0, 4'h0);
        readReg1 = 4'h0; readReg2 = 4'h0; rfData1 = 32'h0; rfData2 = 32'h0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst count", 32'(count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst we", 32'(writeEnable), 32'd0);
        chk("rst wdest", 32'(writeDestination), 32'd0);
        chk("rst wdata", writeData, 32'd0);
        chk("rst memReady", 32'(memReady), 32'd1);
        chk("rst aluReady", 32'(aluReady), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk); #2;
        chk("release we", 32'(writeEnable), 32'd0);
        chk("release count", 32'(count), 32'd0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].av, vecs[i].ad, vecs[i].adat);
            readReg1 = vecs[i].rr1; readReg2 = vecs[i].rr2;
            rfData1 = vecs[i].rf1; rfData2 = vecs[i].rf2;
            #2;
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d we", i), 32'(writeEnable), 32'(vecs[i].we));
            chk($sformatf("v%0d wdest", i), 32'(writeDestination), 32'(vecs[i].wdest));
            chk($sformatf("v%0d wdata", i), writeData, vecs[i].wdata);
            chk($sformatf("v%0d memReady", i), 32'(memReady), 32'(vecs[i].mrdy));
            chk($sformatf("v%0d aluReady", i), 32'(aluReady), 32'(vecs[i].ardy));
            chk($sformatf("v%0d readData1", i), readData1, vecs[i].rd1);
            chk($sformatf("v%0d readData2", i), readData2, vecs[i].rd2);
        end

        // Ten back-to-back single writes: pointers wrap past DEPTH twice.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            drive(k < 10, 4'(k), 32'(k), 1'b0, 4'h0, 32'h0);
            #2;
            if (k == 0) begin
                chk("wrap0 count", 32'(count), 32'd0);
            end else begin
                chk($sformatf("wrap%0d count", k), 32'(count), 32'd1);
                chk($sformatf("wrap%0d we", k), 32'(writeEnable), 32'd1);
                chk($sformatf("wrap%0d wdest", k), 32'(writeDestination), 32'(k - 1));
                chk($sformatf("wrap%0d wdata", k), writeData, 32'(k - 1));
            end
        end
        @(negedge clk); #2;
        chk("wrap end count", 32'(count), 32'd0);
        chk("wrap end empty", 32'(empty), 32'd1);

        // Reset pulse between edges with three entries queued.
        @(negedge clk);
        drive(1'b1, 4'hA, 32'hA0, 1'b1, 4'hB, 32'hB0);
        @(negedge clk);
        drive(1'b1, 4'hC, 32'hC0, 1'b1, 4'hD, 32'hD0);
        @(negedge clk);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        #2;
        chk("mid pre count", 32'(count), 32'd3);
        chk("mid pre wdest", 32'(writeDestination), 32'hB);
        reset = 1'b0;
        #1;
        chk("mid rst count", 32'(count), 32'd0);
        chk("mid rst we", 32'(writeEnable), 32'd0);
        chk("mid rst empty", 32'(empty), 32'd1);
        chk("mid rst wdata", writeData, 32'd0);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            chk($sformatf("mid post%0d we", k), 32'(writeEnable), 32'd0);
            chk($sformatf("mid post%0d count", k), 32'(count), 32'd0);
        end

        // DEPTH=2 instance: full and ready boundaries.
        @(negedge clk); drive2(1'b1, 4'h1, 1'b1, 4'h2); #2;
        chk2("d2 s0", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        @(negedge clk); drive2(1'b1, 4'h3, 1'b1, 4'h4); #2;
        chk2("d2 s1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1);
        @(negedge clk); #2;
        chk2("d2 s2", 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2);
        @(negedge clk); drive2(1'b0, 4'h3, 1'b1, 4'h4); #2;
        chk2("d2 s3", 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
        @(negedge clk); drive2(1'b0, 4'h0, 1'b0, 4'h0); #2;
        chk2("d2 s4", 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4);
        @(negedge clk); #2;
        chk2("d2 s5", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        chk("d2 s5 empty", 32'(empty2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
